timer_bank_ctrl: RTL

Controller for the four GBA hardware timers. It decodes CPU halfword writes to TMxCNT_L/TMxCNT_H into per-channel reload and control state, and runs one shared free-running prescaler. It sequences each channel's 16-bit counter: start-edge reload, prescaled or cascaded increment, and overflow reload. It drives per-channel overflow strobes and IRQ request pulses to the interrupt controller and returns live counter values on CPU reads.

---
 rtl/timer_bank_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/timer_bank_ctrl.sv
`default_nettype none
// ============================================================================
// timer_bank_ctrl : four-channel 16-bit timer bank with a shared prescaler,
//                   cascade chaining, overflow/IRQ pulses and CPU access.
// Revision 1.0
// ============================================================================
module timer_bank_ctrl #(
    parameter int NUM_TIMERS = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clock_16,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [2:0]            wr_addr,
    input  logic [CNT_W-1:0]      wr_data,
    input  logic [2:0]            rd_addr,
    output logic [CNT_W-1:0]      rd_data,
    output logic [NUM_TIMERS-1:0] overflow,
    output logic [NUM_TIMERS-1:0] irq_req
);

    localparam logic [CNT_W-1:0] c_ctrl_mask     = CNT_W'(16'h00C7);
    localparam logic [CNT_W-1:0] c_ctrl_mask_ch0 = CNT_W'(16'h00C3);
    localparam logic [CNT_W-1:0] c_cnt_max       = '1;

    logic [9:0]            div_q, div_d;
    logic [CNT_W-1:0]      cnt_q    [NUM_TIMERS];
    logic [CNT_W-1:0]      cnt_d    [NUM_TIMERS];
    logic [CNT_W-1:0]      reload_q [NUM_TIMERS];
    logic [CNT_W-1:0]      reload_d [NUM_TIMERS];
    logic [CNT_W-1:0]      ctrl_q   [NUM_TIMERS];
    logic [CNT_W-1:0]      ctrl_d   [NUM_TIMERS];
    logic [CNT_W-1:0]      rd_data_q, rd_data_d;
    logic [NUM_TIMERS-1:0] overflow_q, overflow_d;
    logic [NUM_TIMERS-1:0] irq_req_q, irq_req_d;

    logic [3:0] w_tick;
    logic       w_hit, w_ctrl_wr, w_rl_wr, w_start, w_stop;
    logic       w_src, w_inc, w_wrap, w_carry;

    always_comb begin
        div_d     = div_q + 10'd1;
        w_tick[0] = 1'b1;
        w_tick[1] = &div_q[5:0];
        w_tick[2] = &div_q[7:0];
        w_tick[3] = &div_q;

        overflow_d = '0;
        irq_req_d  = '0;
        w_hit      = 1'b0;
        w_ctrl_wr  = 1'b0;
        w_rl_wr    = 1'b0;
        w_start    = 1'b0;
        w_stop     = 1'b0;
        w_src      = 1'b0;
        w_inc      = 1'b0;
        w_wrap     = 1'b0;
        // Carry ripples channel-to-channel so a whole cascade chain can wrap in one edge.
        w_carry    = 1'b0;

        for (int i = 0; i < NUM_TIMERS; i++) begin
            w_hit     = wr_en && (wr_addr[2:1] == i[1:0]);
            w_ctrl_wr = w_hit && wr_addr[0];
            w_rl_wr   = w_hit && !wr_addr[0];
            w_start   = w_ctrl_wr && wr_data[7] && !ctrl_q[i][7];
            w_stop    = w_ctrl_wr && !wr_data[7];
            w_src     = ctrl_q[i][2] ? w_carry : w_tick[ctrl_q[i][1:0]];
            w_inc     = ctrl_q[i][7] && !w_stop && w_src;
            w_wrap    = w_inc && (cnt_q[i] == c_cnt_max);

            reload_d[i] = w_rl_wr ? wr_data : reload_q[i];
            ctrl_d[i]   = w_ctrl_wr ? (wr_data & ((i == 0) ? c_ctrl_mask_ch0 : c_ctrl_mask))
                                    : ctrl_q[i];

            // An overflow coinciding with a reload write picks up the new reload value.
            if (w_start)
                cnt_d[i] = reload_q[i];
            else if (w_wrap)
                cnt_d[i] = reload_d[i];
            else if (w_inc)
                cnt_d[i] = cnt_q[i] + 1'b1;
            else
                cnt_d[i] = cnt_q[i];

            overflow_d[i] = w_wrap;
            irq_req_d[i]  = w_wrap && ctrl_q[i][6];
            w_carry       = w_wrap;
        end

        rd_data_d = rd_addr[0] ? ctrl_q[rd_addr[2:1]] : cnt_q[rd_addr[2:1]];
    end

    always_ff @(posedge clock_16 or posedge reset) begin
        if (reset) begin
            div_q      <= '0;
            rd_data_q  <= '0;
            overflow_q <= '0;
            irq_req_q  <= '0;
            for (int i = 0; i < NUM_TIMERS; i++) begin
                cnt_q[i]    <= '0;
                reload_q[i] <= '0;
                ctrl_q[i]   <= '0;
            end
        end else begin
            div_q      <= div_d;
            rd_data_q  <= rd_data_d;
            overflow_q <= overflow_d;
            irq_req_q  <= irq_req_d;
            for (int i = 0; i < NUM_TIMERS; i++) begin
                cnt_q[i]    <= cnt_d[i];
                reload_q[i] <= reload_d[i];
                ctrl_q[i]   <= ctrl_d[i];
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign overflow = overflow_q;
    assign irq_req  = irq_req_q;

endmodule
`default_nettype wire
